// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of an 8-to-1 serial line, drives mux select and registered data bit (optional burst limit: RR_BURST_LIMIT_EN)
module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] req,
    input  logic [0:7] D,
    output logic [0:7] gnt,
    output logic [0:2] S,
    output logic       busy,
    output logic       Y
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, nxt_state;
    logic [2:0] own, nxt_own, ptr, nxt_ptr, win;
    logic [0:7] nxt_gnt;
    logic       any_req, rel, nxt_y;
`ifdef RR_BURST_LIMIT_EN
    logic [CNT_W-1:0] cnt, nxt_cnt;
`endif

    assign any_req = |req;
    assign S       = {own[0], own[1], own[2]};
    assign busy    = |gnt;

`ifdef RR_BURST_LIMIT_EN
    assign rel = (state == IDLE) || !req[own] || (cnt == CNT_W'(MAX_BURST - 1));
`else
    assign rel = (state == IDLE) || !req[own];
`endif

    // first asserted request searching ptr, ptr+1, ... wrapping mod 8
    always_comb begin
        win = ptr;
        for (int i = 7; i >= 0; i--)
            if (req[ptr + 3'(i)]) win = ptr + 3'(i);
    end

    // next owner, pointer, grant vector and data bit
    always_comb begin
        nxt_state = state;
        nxt_own   = own;
        nxt_ptr   = ptr;
`ifdef RR_BURST_LIMIT_EN
        nxt_cnt   = (cnt == '1) ? cnt : cnt + 1'b1;
`endif
        if (rel) begin
            nxt_state = any_req ? GRANT : IDLE;
            if (any_req) begin
                nxt_own = win;
                nxt_ptr = win + 3'd1;
`ifdef RR_BURST_LIMIT_EN
                nxt_cnt = '0;
`endif
            end
        end
        nxt_gnt = '0;
        if (nxt_state == GRANT) nxt_gnt[nxt_own] = 1'b1;
        nxt_y = (nxt_state == GRANT) && D[nxt_own];
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            own   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            Y     <= 1'b0;
`ifdef RR_BURST_LIMIT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= nxt_state;
            own   <= nxt_own;
            ptr   <= nxt_ptr;
            gnt   <= nxt_gnt;
            Y     <= nxt_y;
`ifdef RR_BURST_LIMIT_EN
            cnt   <= nxt_cnt;
`endif
        end
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares the 8-to-1 multiplexer datapath among eight requesters. It grants one requester at a time and drives the 3-bit mux select from the grant. It also registers the selected data bit into a single shared output. It sits directly in front of the 8-to-1 multiplexer, or replaces its select logic, in any datapath where eight sources contend for one serial line.

## Interface
- MAX_BURST, 4, maximum consecutive grant cycles per owner when the burst limit is compiled in; legal range 1..255
- CNT_W, 8, width of the burst counter; must satisfy 2^CNT_W > MAX_BURST
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  [0:7]  request per source; req[i] high = source i wants the line
- D  input  [0:7]  data bit per source; D[i] belongs to requester i
- gnt  output  [0:7]  one-hot grant, registered; all zero when idle
- S  output  [0:2]  mux select = index of the current owner, registered; S[0] is the LSB of the index, matching mux convention
- busy  output  1  high while any grant is active
- Y  output  1  registered D[S] while busy, else 0

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: owner index held in S.
- Round-robin pointer ptr (3 bits) sets where the search starts.
  - Search order is ptr, ptr+1, …, ptr+7, modulo 8.
  - First asserted req in that order wins.
- IDLE:
  - If any req is high at the clock edge, enter GRANT with the winner. Load gnt, S and busy, clear the burst counter, and set ptr to winner+1 (mod 8).
  - If no req is high, remain in IDLE with gnt=0 and busy=0. S holds its last value.
- GRANT, release condition:
  - req[owner] is low at the edge, or
  - with RR_BURST_LIMIT_EN only, the burst counter equals MAX_BURST−1.
- GRANT, on release:
  - Arbitrate in the same edge among all req, searching from ptr (owner+1).
  - A different winner moves directly to GRANT with the new owner, with zero bubble cycles.
  - If the only requester is the releasing owner (burst-limit case, req still high), it is re-granted and its counter cleared.
  - If no req is high, go to IDLE.
- GRANT, no release: hold the owner and increment the burst counter (saturating at 2^CNT_W−1).
- Y is registered each edge:
  - Y ← D[next S] when next state is GRANT.
  - Y ← 0 when next state is IDLE.
- Simultaneous requests are resolved purely by the pointer; there is no fixed priority.
- A requester dropping req while not owner has no effect.

## Timing
- Reset (rst_n low, asynchronous) values: gnt=0, S=0, busy=0, Y=0, state IDLE, ptr=0, counter=0. Outputs update on the falling edge of rst_n without waiting for a clock.
- Reset deasserted mid-burst: the grant is lost and arbitration restarts from source 0 on the first edge with rst_n high.
- req→gnt latency: 1 cycle. A req first high before edge k gives gnt at edge k.
- Release latency: 1 cycle. req[owner] dropping before edge k frees the line at edge k. The next owner appears at the same edge k.
- Y lags D by one cycle. Y at cycle k+1 equals D[S] sampled at edge k. The first Y bit of a grant is valid in the same cycle gnt first rises.
- gnt is always one-hot or zero. busy = OR of gnt. S always equals the index of the set gnt bit while busy.

## Configuration
- RR_BURST_LIMIT_EN defined:
  - An owner holding req continuously is forcibly released after exactly MAX_BURST grant cycles.
  - If another source is requesting, it takes over.
- RR_BURST_LIMIT_EN undefined:
  - No burst counter logic.
  - The owner keeps the line until it drops req.
  - MAX_BURST and CNT_W are ignored.

## Test plan
- Reset: assert rst_n=0 mid-grant with req=8'hFF → gnt=0, S=0, busy=0, Y=0 immediately. Release rst_n with req=8'hFF → gnt=8'b1000_0000 (source 0) at the first edge.
- Single requester: req[5]=1 for 3 cycles with D[5] toggling 1,0,1 → gnt[5] for 3 cycles, S=5, and Y follows D[5] with 1-cycle lag. busy drops 1 cycle after req[5] falls.
- Rotation without the macro: req=8'hFF held, each owner drops req for one cycle after 2 cycles of grant → grant order 0,1,2,…,7,0 with no idle cycle between owners.
- Burst limit with the macro and MAX_BURST=4: req[2] and req[6] held high → gnt alternates 2,6,2,6 in 4-cycle runs. With only req[3] held, gnt[3] stays continuously asserted (re-grant), with no gap.
- Pointer fairness: owner 6 releases while req[7] and req[1] are both high → 7 is granted, then 1.
- Idle data gating: req=0 with D=8'hFF → Y=0, busy=0, and S holds its previous value.
